// File: rtl/music_note_sequencer.sv
// Melody playback engine: 16-entry note RAM played as a square wave,
// with beat strobe and note index exported for the VGA renderer.
module music_note_sequencer #(
  parameter int PRESCALE   = 4,
  parameter int BEAT_TICKS = 6_250_000,
  parameter int GAP_TICKS  = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic        audio_out,
  output logic        playing,
  output logic [3:0]  note_idx,
  output logic        note_valid,
  output logic        beat_pulse,
  output logic        done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_TICKS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [16];
  logic [3:0]    idx_q, idx_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [3:0]    beats_q, beats_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [11:0]   hp_cnt_q, hp_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          audio_q, audio_d;
  logic          done_q, done_d;

  logic [15:0] cur;
  logic [3:0]  cur_dur;
  logic [11:0] cur_hp;
  logic [3:0]  nxt;
  logic [3:0]  nxt_dur;
  logic [3:0]  mem0_dur;
  logic [3:0]  start_dur;
  logic        tick;
  logic        beat_wrap;
  logic        gap_end;
  logic        wr_ok;

  assign cur       = mem_q[idx_q];
  assign cur_dur   = cur[15:12];
  assign cur_hp    = cur[11:0];
  assign nxt       = 4'(idx_q + 4'd1);
  assign nxt_dur   = mem_q[nxt][15:12];
  assign mem0_dur  = mem_q[0][15:12];
  assign tick      = (pre_q == PRE_LAST);
  assign beat_wrap = (beat_q == BEAT_LAST);
  assign gap_end   = (gap_q == GAP_LAST);
  assign wr_ok     = wr_en && (state_q == IDLE);

  // A same-cycle write to entry 0 must be visible to the start decision.
  assign start_dur = (wr_en && wr_addr == 4'd0) ? wr_data[15:12] : mem0_dur;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    beats_d  = beats_q;
    pre_d    = pre_q;
    hp_cnt_d = hp_cnt_q;
    gap_d    = gap_q;
    audio_d  = audio_q;
    done_d   = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      idx_d    = '0;
      beat_d   = '0;
      beats_d  = '0;
      pre_d    = '0;
      hp_cnt_d = '0;
      gap_d    = '0;
      audio_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_d    = '0;
            beat_d   = '0;
            beats_d  = '0;
            pre_d    = '0;
            hp_cnt_d = '0;
            gap_d    = '0;
            audio_d  = 1'b0;
            if (start_dur == 4'd0) done_d = 1'b1;
            else state_d = PLAY;
          end
        end
        PLAY: begin
          beat_d = beat_wrap ? '0 : BW'(beat_q + BW'(1));
          pre_d  = tick ? '0 : PW'(pre_q + PW'(1));
          if (cur_hp == 12'd0) begin
            audio_d  = 1'b0;
            hp_cnt_d = '0;
          end else if (tick) begin
            if (hp_cnt_q == 12'(cur_hp - 12'd1)) begin
              audio_d  = ~audio_q;
              hp_cnt_d = '0;
            end else begin
              hp_cnt_d = 12'(hp_cnt_q + 12'd1);
            end
          end
          if (beat_wrap) begin
            beats_d = 4'(beats_q + 4'd1);
            if (4'(beats_q + 4'd1) == cur_dur) begin
              state_d  = GAP;
              beat_d   = '0;
              beats_d  = '0;
              pre_d    = '0;
              hp_cnt_d = '0;
              audio_d  = 1'b0;
            end
          end
        end
        GAP: begin
          audio_d = 1'b0;
          gap_d   = GW'(gap_q + GW'(1));
          if (gap_end) begin
            gap_d = '0;
            if (idx_q == 4'd15 || nxt_dur == 4'd0) begin
              idx_d = '0;
              if (loop_en && mem0_dur != 4'd0) begin
                state_d = PLAY;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              idx_d   = nxt;
              state_d = PLAY;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      beat_q   <= '0;
      beats_q  <= '0;
      pre_q    <= '0;
      hp_cnt_q <= '0;
      gap_q    <= '0;
      audio_q  <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      beat_q   <= beat_d;
      beats_q  <= beats_d;
      pre_q    <= pre_d;
      hp_cnt_q <= hp_cnt_d;
      gap_q    <= gap_d;
      audio_q  <= audio_d;
      done_q   <= done_d;
      if (wr_ok) mem_q[wr_addr] <= wr_data;
    end
  end

  assign audio_out  = audio_q;
  assign playing    = (state_q != IDLE);
  assign note_idx   = idx_q;
  assign note_valid = (state_q == PLAY) && (cur_hp != 12'd0);
  assign beat_pulse = (state_q == PLAY) && beat_wrap;
  assign done       = done_q;

endmodule

// File: tb/tb_music_note_sequencer.sv
// Bench for music_note_sequencer: directed scenarios plus randomized
// traffic checked every cycle against a behavioural note-timing model.
module tb_music_note_sequencer;

  localparam int P  = 2;
  localparam int BT = 20;
  localparam int G  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        audio_out;
  logic        playing;
  logic [3:0]  note_idx;
  logic        note_valid;
  logic        beat_pulse;
  logic        done;

  always #5 clk = ~clk;

  music_note_sequencer #(
    .PRESCALE  (P),
    .BEAT_TICKS(BT),
    .GAP_TICKS (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .audio_out (audio_out),
    .playing   (playing),
    .note_idx  (note_idx),
    .note_valid(note_valid),
    .beat_pulse(beat_pulse),
    .done      (done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // Model: phase 0 idle, 1 playing a note, 2 gap; m_k is the 1-based
  // cycle number within the current phase.
  logic [15:0] m_mem [16];
  int m_ph   = 0;
  int m_idx  = 0;
  int m_k    = 0;
  bit m_done = 1'b0;

  function automatic int dur_of(input logic [15:0] e);
    return int'(e[15:12]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_ph = 0;
      m_idx = 0;
      m_k = 0;
      m_done = 1'b0;
    end else begin
      bit nd;
      int nx;
      nd = 1'b0;
      if (m_ph == 0 && wr_en) m_mem[wr_addr] = wr_data;
      if (stop) begin
        m_ph = 0;
        m_idx = 0;
      end else begin
        case (m_ph)
          0: if (start) begin
            m_idx = 0;
            if (dur_of(m_mem[0]) == 0) nd = 1'b1;
            else begin m_ph = 1; m_k = 1; end
          end
          1: if (m_k == dur_of(m_mem[m_idx]) * BT) begin
            m_ph = 2; m_k = 1;
          end else m_k++;
          2: if (m_k == G) begin
            nx = (m_idx + 1) % 16;
            if (m_idx == 15 || dur_of(m_mem[nx]) == 0) begin
              m_idx = 0;
              if (loop_en && dur_of(m_mem[0]) != 0) begin
                m_ph = 1; m_k = 1;
              end else begin
                m_ph = 0; nd = 1'b1;
              end
            end else begin
              m_idx = nx; m_ph = 1; m_k = 1;
            end
          end else m_k++;
          default: ;
        endcase
      end
      m_done = nd;
    end
  end

  int cnt_play, cnt_done, cnt_beat, cnt_tog, cnt_valid;
  int first_rise, first_beat;
  logic prev_audio = 1'b0;

  always @(posedge clk) begin
    int hp;
    bit e_valid, e_audio, e_beat;
    logic [8:0] e_vec, a_vec;
    #1;
    hp = int'(m_mem[m_idx][11:0]);
    e_valid = (m_ph == 1) && (hp != 0);
    e_audio = e_valid && ((((m_k - 1) / (hp * P)) % 2) == 1);
    e_beat  = (m_ph == 1) && ((m_k % BT) == 0);
    e_vec = {m_ph != 0, 4'(m_idx), e_valid, e_audio, e_beat, m_done};
    a_vec = {playing, note_idx, note_valid, audio_out, beat_pulse, done};
    if (chk_en) chk("cycle_outputs", longint'(a_vec), longint'(e_vec));
    if (playing) begin
      cnt_play++;
      if (audio_out && !prev_audio && first_rise == 0) first_rise = cnt_play;
      if (beat_pulse && first_beat == 0) first_beat = cnt_play;
    end
    if (audio_out != prev_audio) cnt_tog++;
    if (done) cnt_done++;
    if (beat_pulse) cnt_beat++;
    if (note_valid) cnt_valid++;
    prev_audio = audio_out;
  end

  task automatic clr;
    cnt_play = 0; cnt_done = 0; cnt_beat = 0; cnt_tog = 0;
    cnt_valid = 0; first_rise = 0; first_beat = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0; loop_en = 1'b0;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    clr();
    do_reset();
    chk_en = 1'b1;
    chk("rst_playing", playing, 0);
    chk("rst_audio", audio_out, 0);
    chk("rst_idx", note_idx, 0);
    chk("rst_done", done, 0);

    // empty RAM
    clr(); pulse_start(); cycles(5);
    chk("t1_done", cnt_done, 1);
    chk("t1_play", cnt_play, 0);
    chk("t1_tog", cnt_tog, 0);

    // single note dur 2 hp 3
    do_reset();
    wr(4'd0, 16'h2003);
    clr(); pulse_start(); cycles(60);
    chk("t2_play", cnt_play, 44);
    chk("t2_beats", cnt_beat, 2);
    chk("t2_first_beat", first_beat, 20);
    chk("t2_first_rise", first_rise, 7);
    chk("t2_tog", cnt_tog, 6);
    chk("t2_valid", cnt_valid, 40);
    chk("t2_done", cnt_done, 1);

    // rest then tone
    do_reset();
    wr(4'd0, 16'h1000);
    wr(4'd1, 16'h1005);
    clr(); pulse_start(); cycles(60);
    chk("t3_play", cnt_play, 48);
    chk("t3_valid", cnt_valid, 20);
    chk("t3_first_rise", first_rise, 35);
    chk("t3_tog", cnt_tog, 2);
    chk("t3_done", cnt_done, 1);

    // looping
    do_reset();
    wr(4'd0, 16'h1001);
    wr(4'd1, 16'h1002);
    loop_en = 1'b1;
    clr(); pulse_start(); cycles(150);
    chk("t4_loop_done", cnt_done, 0);
    chk("t4_loop_playing", playing, 1);
    loop_en = 1'b0;
    cycles(60);
    chk("t4_end_done", cnt_done, 1);
    chk("t4_end_playing", playing, 0);

    // stop mid-play, dropped write
    do_reset();
    wr(4'd0, 16'h2003);
    clr(); pulse_start(); cycles(8);
    wr(4'd0, 16'h1001);
    cycles(4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t5_stop_playing", playing, 0);
    chk("t5_stop_audio", audio_out, 0);
    chk("t5_stop_idx", note_idx, 0);
    chk("t5_stop_valid", note_valid, 0);
    cycles(3);
    chk("t5_stop_done", cnt_done, 0);
    clr(); pulse_start(); cycles(60);
    chk("t5_replay_play", cnt_play, 44);
    chk("t5_replay_beats", cnt_beat, 2);
    chk("t5_replay_done", cnt_done, 1);

    // full 16-entry song
    do_reset();
    for (int i = 0; i < 16; i++) wr(4'(i), 16'h1001);
    clr(); pulse_start(); cycles(420);
    chk("t6_play", cnt_play, 384);
    chk("t6_valid", cnt_valid, 320);
    chk("t6_tog", cnt_tog, 160);
    chk("t6_done", cnt_done, 1);

    // randomized traffic
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int j = 0; j < 10; j++)
        wr(4'($urandom_range(0, 15)),
           {4'($urandom_range(1, 3)), 9'd0, 3'($urandom_range(0, 7))});
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        start = ($urandom_range(0, 9) == 0);
        stop  = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 79) == 0) loop_en = ~loop_en;
        wr_en   = ($urandom_range(0, 7) == 0);
        wr_addr = 4'($urandom_range(0, 15));
        wr_data = {4'($urandom_range(0, 3)), 9'd0, 3'($urandom_range(0, 7))};
      end
      @(negedge clk);
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    end

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
